// File: rtl/tag_cam.sv
// rtl/tag_cam.sv - clocked tag CAM with registered lookup, victim/explicit writes, invalidate, flush
// Lookups see pre-edge state; victim is the lowest invalid entry, else the round-robin pointer.
module tag_cam #(
  parameter int ENTRY_WIDTH = 28,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_LookupValid,
  input  logic [ENTRY_WIDTH-1:0] in_LookupKey,
  output logic                   out_MatchValid,
  output logic                   out_MatchHit,
  output logic [INDEX_WIDTH-1:0] out_MatchIndex,
  output logic                   out_MultiHit,
  input  logic                   in_WriteEnable,
  input  logic [ENTRY_WIDTH-1:0] in_WriteKey,
  input  logic                   in_WriteUseVictim,
  input  logic [INDEX_WIDTH-1:0] in_WriteEntry,
  output logic [INDEX_WIDTH-1:0] out_VictimEntry,
  input  logic                   in_InvalidateEnable,
  input  logic [INDEX_WIDTH-1:0] in_InvalidateEntry,
  input  logic                   in_FlushAll,
  output logic                   out_Full,
  output logic [INDEX_WIDTH:0]   out_ValidCount
);

  logic [ENTRY_WIDTH-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       valid_d;
  logic [INDEX_WIDTH-1:0] rr_ptr;
  logic [DEPTH-1:0]       match_vec;
  logic [INDEX_WIDTH-1:0] match_idx;
  logic [INDEX_WIDTH-1:0] victim_idx;
  logic [INDEX_WIDTH-1:0] write_idx;
  logic [INDEX_WIDTH:0]   valid_count;
  logic                   multi;
  logic                   write_fire;
  logic                   rr_advance;

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = valid_q[i] && (tag_q[i] == in_LookupKey);
    end
  end

  always_comb begin
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) match_idx = INDEX_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits matched.
  assign multi = |(match_vec & (match_vec - DEPTH'(1)));

  always_comb begin
    victim_idx = rr_ptr;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) victim_idx = INDEX_WIDTH'(i);
    end
  end

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_count = valid_count + (INDEX_WIDTH + 1)'(valid_q[i]);
    end
  end

  assign out_VictimEntry = victim_idx;
  assign out_Full        = &valid_q;
  assign out_ValidCount  = valid_count;

  assign write_idx  = in_WriteUseVictim ? victim_idx : in_WriteEntry;
  assign write_fire = in_WriteEnable && !in_FlushAll;
  assign rr_advance = write_fire && in_WriteUseVictim && out_Full;

  // Write is applied after invalidate so a same-index collision leaves the entry valid.
  always_comb begin
    valid_d = valid_q;
    if (in_FlushAll) begin
      valid_d = '0;
    end else begin
      if (in_InvalidateEnable) valid_d[in_InvalidateEntry] = 1'b0;
      if (in_WriteEnable)      valid_d[write_idx]          = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      rr_ptr  <= '0;
    end else begin
      valid_q <= valid_d;
      if (rr_advance) rr_ptr <= rr_ptr + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && write_fire) tag_q[write_idx] <= in_WriteKey;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_MatchValid <= 1'b0;
      out_MatchHit   <= 1'b0;
      out_MatchIndex <= '0;
      out_MultiHit   <= 1'b0;
    end else begin
      out_MatchValid <= in_LookupValid;
      out_MatchHit   <= in_LookupValid && (|match_vec);
      out_MatchIndex <= in_LookupValid ? match_idx : '0;
      out_MultiHit   <= in_LookupValid && multi;
    end
  end

endmodule

// File: tb/tb_tag_cam.sv
// tb/tb_tag_cam.sv - directed and randomized bench for tag_cam against an array-based reference model
module tb_tag_cam;
  localparam int EW = 28;
  localparam int D  = 8;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_LookupValid;
  logic [EW-1:0] in_LookupKey;
  logic          out_MatchValid;
  logic          out_MatchHit;
  logic [IW-1:0] out_MatchIndex;
  logic          out_MultiHit;
  logic          in_WriteEnable;
  logic [EW-1:0] in_WriteKey;
  logic          in_WriteUseVictim;
  logic [IW-1:0] in_WriteEntry;
  logic [IW-1:0] out_VictimEntry;
  logic          in_InvalidateEnable;
  logic [IW-1:0] in_InvalidateEntry;
  logic          in_FlushAll;
  logic          out_Full;
  logic [IW:0]   out_ValidCount;

  always #5 clock = ~clock;

  tag_cam #(.ENTRY_WIDTH(EW), .DEPTH(D), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .in_LookupValid(in_LookupValid), .in_LookupKey(in_LookupKey),
    .out_MatchValid(out_MatchValid), .out_MatchHit(out_MatchHit),
    .out_MatchIndex(out_MatchIndex), .out_MultiHit(out_MultiHit),
    .in_WriteEnable(in_WriteEnable), .in_WriteKey(in_WriteKey),
    .in_WriteUseVictim(in_WriteUseVictim), .in_WriteEntry(in_WriteEntry),
    .out_VictimEntry(out_VictimEntry),
    .in_InvalidateEnable(in_InvalidateEnable), .in_InvalidateEntry(in_InvalidateEntry),
    .in_FlushAll(in_FlushAll), .out_Full(out_Full), .out_ValidCount(out_ValidCount)
  );

  logic [EW-1:0] m_tag [D];
  bit            m_valid [D];
  int            m_rr;
  int            compared = 0;
  int            mismatched = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  function automatic int m_victim();
    for (int i = 0; i < D; i++) if (!m_valid[i]) return i;
    return m_rr;
  endfunction

  task automatic idle();
    reset = 1'b0; in_LookupValid = 1'b0; in_LookupKey = '0;
    in_WriteEnable = 1'b0; in_WriteKey = '0; in_WriteUseVictim = 1'b0; in_WriteEntry = '0;
    in_InvalidateEnable = 1'b0; in_InvalidateEntry = '0; in_FlushAll = 1'b0;
  endtask

  task automatic lookup(input logic [EW-1:0] key);
    in_LookupValid = 1'b1; in_LookupKey = key;
  endtask

  task automatic vwrite(input logic [EW-1:0] key);
    in_WriteEnable = 1'b1; in_WriteKey = key; in_WriteUseVictim = 1'b1;
  endtask

  task automatic xwrite(input logic [EW-1:0] key, input int idx);
    in_WriteEnable = 1'b1; in_WriteKey = key; in_WriteUseVictim = 1'b0; in_WriteEntry = IW'(idx);
  endtask

  // Model the edge from the driven inputs, clock once, then compare every output.
  task automatic step(input string name);
    int  hits[$];
    bit  e_mv;
    int  widx;
    bit  full_pre;
    for (int i = 0; i < D; i++)
      if (m_valid[i] && m_tag[i] == in_LookupKey) hits.push_back(i);
    e_mv = in_LookupValid && !reset;
    if (reset) begin
      for (int i = 0; i < D; i++) m_valid[i] = 0;
      m_rr = 0;
    end else if (in_FlushAll) begin
      for (int i = 0; i < D; i++) m_valid[i] = 0;
    end else begin
      full_pre = (m_count() == D);
      widx = in_WriteUseVictim ? m_victim() : int'(in_WriteEntry);
      if (in_InvalidateEnable) m_valid[in_InvalidateEntry] = 0;
      if (in_WriteEnable) begin
        m_tag[widx] = in_WriteKey;
        m_valid[widx] = 1;
        if (in_WriteUseVictim && full_pre) m_rr = (m_rr + 1) % D;
      end
    end
    @(posedge clock);
    #1;
    idle();
    chk({name, ".valid"}, 32'(out_MatchValid), 32'(e_mv));
    chk({name, ".hit"},   32'(out_MatchHit),   32'(e_mv && hits.size() > 0));
    chk({name, ".index"}, 32'(out_MatchIndex), (e_mv && hits.size() > 0) ? hits[0] : 0);
    chk({name, ".multi"}, 32'(out_MultiHit),   32'(e_mv && hits.size() > 1));
    chk({name, ".victim"}, 32'(out_VictimEntry), m_victim());
    chk({name, ".full"},   32'(out_Full),        32'(m_count() == D));
    chk({name, ".count"},  32'(out_ValidCount),  m_count());
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin m_tag[i] = '0; m_valid[i] = 0; end
    m_rr = 0;
    idle();
    @(negedge clock);

    reset = 1'b1;
    step("reset");
    chk("reset.victim_zero", 32'(out_VictimEntry), 0);

    for (int k = 0; k < D; k++) begin
      chk("fill.victim_pre", 32'(out_VictimEntry), k);
      vwrite(EW'(32'h100 + k));
      step("fill");
      chk("fill.count", 32'(out_ValidCount), k + 1);
    end
    chk("fill.full", 32'(out_Full), 1);
    chk("fill.victim_rr", 32'(out_VictimEntry), 0);

    lookup(EW'(32'h105)); step("lookup_hit");
    chk("lookup_hit.index5", 32'(out_MatchIndex), 5);
    lookup(EW'(32'h999)); step("lookup_miss");
    chk("lookup_miss.hit0", 32'(out_MatchHit), 0);

    for (int k = 0; k < D + 1; k++) begin
      chk("rr.victim_pre", 32'(out_VictimEntry), k % D);
      vwrite(EW'(32'h100 + (k % D)));
      step("rr");
    end
    chk("rr.wrapped_to_1", 32'(out_VictimEntry), 1);
    xwrite(EW'(32'h106), 6); step("rr_explicit");
    chk("rr.explicit_no_move", 32'(out_VictimEntry), 1);

    in_InvalidateEnable = 1'b1; in_InvalidateEntry = 3'd3; step("inval3");
    chk("inval3.victim", 32'(out_VictimEntry), 3);
    chk("inval3.count", 32'(out_ValidCount), 7);
    xwrite(EW'(32'h105), 3); step("dup_write");
    lookup(EW'(32'h105)); step("dup_lookup");
    chk("dup.index3", 32'(out_MatchIndex), 3);
    chk("dup.multi", 32'(out_MultiHit), 1);

    lookup(EW'(32'h200)); vwrite(EW'(32'h200)); step("same_cycle_lw");
    chk("same_cycle_lw.hit0", 32'(out_MatchHit), 0);
    lookup(EW'(32'h200)); step("next_cycle_l");
    chk("next_cycle_l.hit1", 32'(out_MatchHit), 1);

    xwrite(EW'(32'h444), 4); in_InvalidateEnable = 1'b1; in_InvalidateEntry = 3'd4;
    step("wr_inv_same");
    lookup(EW'(32'h444)); step("wr_inv_lookup");
    chk("wr_inv.index4", 32'(out_MatchIndex), 4);

    in_FlushAll = 1'b1; vwrite(EW'(32'h555)); step("flush_write");
    chk("flush.count0", 32'(out_ValidCount), 0);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      in_FlushAll = ($urandom_range(0, 39) == 0);
      in_LookupValid = $urandom_range(0, 3) != 0;
      in_LookupKey = EW'(32'h10 + $urandom_range(0, 9));
      in_WriteEnable = $urandom_range(0, 1) != 0;
      in_WriteKey = EW'(32'h10 + $urandom_range(0, 7));
      in_WriteUseVictim = $urandom_range(0, 1) != 0;
      in_WriteEntry = IW'($urandom_range(0, D - 1));
      in_InvalidateEnable = ($urandom_range(0, 4) == 0);
      in_InvalidateEntry = IW'($urandom_range(0, D - 1));
      step("rand");
    end

    in_FlushAll = 1'b1; step("pre_reset_flush");
    for (int k = 0; k < D; k++) begin vwrite(EW'(32'h100 + k)); step("refill"); end
    reset = 1'b1; lookup(EW'(32'h102)); vwrite(EW'(32'h777)); step("mid_reset");
    chk("mid_reset.count0", 32'(out_ValidCount), 0);
    lookup(EW'(32'h102)); step("post_reset_lookup");
    chk("post_reset.miss", 32'(out_MatchHit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
